// File: rtl/risc_exec_unit.sv
// Single-issue RISC execution unit: register file, single-cycle ALU and an optional
// restoring divider (enabled by defining RISC_DIV_EN) behind a valid/ready handshake.
module risc_exec_unit #(
  parameter  int WIDTH = 16,
  parameter  int REGS  = 8,
  parameter  int IMM_W = 6,
  localparam int RAW   = $clog2(REGS),
  localparam int IW    = 4 + 2 * RAW + IMM_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IW-1:0]    instr,
  output logic [WIDTH-1:0] result,
  output logic [RAW-1:0]   result_rd,
  output logic             result_valid,
  output logic             err,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b
);

  logic [3:0]       opcode;
  logic [RAW-1:0]   rd, rs1, rs2;
  logic [IMM_W-1:0] imm;
  logic [WIDTH-1:0] regs [REGS];
  logic [WIDTH-1:0] a, b, imm_ext;

  assign opcode  = instr[IW-1 -: 4];
  assign rd      = instr[IW-5 -: RAW];
  assign rs1     = instr[IMM_W+RAW-1 -: RAW];
  assign imm     = instr[IMM_W-1:0];
  assign rs2     = imm[RAW-1:0];
  assign imm_ext = WIDTH'(imm);
  assign a       = (rs1 == '0) ? '0 : regs[rs1];
  assign b       = (rs2 == '0) ? '0 : regs[rs2];

  logic [WIDTH-1:0] alu_res, nxt_a, nxt_b;
  logic             alu_err, alu_wr, alu_vld, div_go, accept;

`ifdef RISC_DIV_EN
  localparam int CNT_W = $clog2(WIDTH);
  typedef enum logic {ST_IDLE, ST_DIV} state_t;
  state_t           state;
  logic [WIDTH-1:0] rem, quo, dvs, rem_n, quo_n;
  logic [RAW-1:0]   div_rd;
  logic [CNT_W-1:0] cnt;

  // One restoring step: shift in the next dividend bit and subtract when it fits.
  // The remainder invariant rem < d keeps a non-negative trial below 2^WIDTH.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] r,
                                                  input logic [WIDTH-1:0] q,
                                                  input logic [WIDTH-1:0] d);
    logic [WIDTH:0] trial;
    trial = {r, q[WIDTH-1]} - {1'b0, d};
    if (!trial[WIDTH]) return {trial[WIDTH-1:0], q[WIDTH-2:0], 1'b1};
    else               return {r[WIDTH-2:0], q[WIDTH-1], q[WIDTH-2:0], 1'b0};
  endfunction

  assign {rem_n, quo_n} = div_step(rem, quo, dvs);
  assign in_ready       = (state == ST_IDLE);
`else
  assign in_ready = 1'b1;
`endif

  assign accept = in_valid & in_ready;

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    alu_wr  = 1'b0;
    alu_vld = 1'b1;
    div_go  = 1'b0;
    nxt_a   = a;
    nxt_b   = b;
    case (opcode)
      4'd0: alu_vld = 1'b0;
      4'd1: begin alu_res = a + b; alu_wr = 1'b1; end
      4'd2: begin alu_res = a - b; alu_wr = 1'b1; end
      4'd3: begin alu_res = a * b; alu_wr = 1'b1; end
`ifdef RISC_DIV_EN
      4'd4: begin
        if (b == '0) begin
          alu_res = '1;
          alu_err = 1'b1;
          alu_wr  = 1'b1;
        end else begin
          alu_vld = 1'b0;
          div_go  = 1'b1;
        end
      end
`endif
      4'd5: begin alu_res = imm_ext; alu_wr = 1'b1; nxt_a = '0; nxt_b = imm_ext; end
      4'd6: begin alu_res = a & b; alu_wr = 1'b1; end
      4'd7: begin alu_res = a | b; alu_wr = 1'b1; end
      default: alu_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REGS; i++) regs[i] <= '0;
      result       <= '0;
      result_rd    <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
      op_a         <= '0;
      op_b         <= '0;
`ifdef RISC_DIV_EN
      state        <= ST_IDLE;
`endif
    end else begin
      result_valid <= 1'b0;
      // Issue edge: capture operands, retire single-cycle ops, launch a division
      if (accept) begin
        op_a <= nxt_a;
        op_b <= nxt_b;
        if (alu_vld) begin
          result       <= alu_res;
          result_rd    <= rd;
          err          <= alu_err;
          result_valid <= 1'b1;
        end
        if (alu_wr && rd != '0) regs[rd] <= alu_res;
`ifdef RISC_DIV_EN
        if (div_go) begin
          state  <= ST_DIV;
          rem    <= '0;
          quo    <= a;
          dvs    <= b;
          div_rd <= rd;
          cnt    <= '0;
        end
`endif
      end
`ifdef RISC_DIV_EN
      // Divide iterations; the final one writes back directly
      if (state == ST_DIV) begin
        rem <= rem_n;
        quo <= quo_n;
        cnt <= cnt + 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) begin
          state        <= ST_IDLE;
          result       <= quo_n;
          result_rd    <= div_rd;
          err          <= 1'b0;
          result_valid <= 1'b1;
          if (div_rd != '0) regs[div_rd] <= quo_n;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_risc_exec_unit.sv
// Scoreboard bench for risc_exec_unit: directed program plus random instructions,
// predicted by an arithmetic reference model; follows RISC_DIV_EN like the design.
module tb_risc_exec_unit;
  localparam int WIDTH = 16;
  localparam int REGS  = 8;
  localparam int IMM_W = 6;
  localparam int RAW   = 3;
  localparam int IW    = 4 + 2 * RAW + IMM_W;
`ifdef RISC_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset, in_valid, in_ready, result_valid, err;
  logic [IW-1:0]    instr;
  logic [WIDTH-1:0] result, op_a, op_b;
  logic [RAW-1:0]   result_rd;

  risc_exec_unit #(.WIDTH(WIDTH), .REGS(REGS), .IMM_W(IMM_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .result(result), .result_rd(result_rd),
    .result_valid(result_valid), .err(err), .op_a(op_a), .op_b(op_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic [RAW-1:0]   rd;
    logic             err;
    int               at;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] mregs [REGS];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every completion strobe must match the oldest prediction, at the predicted cycle
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && result_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result_valid: got result %0h rd %0d, expected no strobe",
                 result, result_rd);
      end else begin
        e = q.pop_front();
        chk("result", result, e.res);
        chk("result_rd", result_rd, e.rd);
        chk("err", err, e.err);
        chk("latency", cyc, e.at);
      end
    end
  end

  function automatic logic [IW-1:0] enc(input int op, input int rd, input int rs1, input int imm);
    return {4'(op), RAW'(rd), RAW'(rs1), IMM_W'(imm)};
  endfunction

  // Reference model: architectural effect of one accepted instruction
  task automatic model(input logic [IW-1:0] ins, output logic long_div,
                       output logic [WIDTH-1:0] ea, output logic [WIDTH-1:0] eb);
    int op, rd, rs1, rs2;
    longint unsigned a, b, v, m;
    logic wr, rep, e;
    op  = int'(ins[IW-1 -: 4]);
    rd  = int'(ins[IW-5 -: RAW]);
    rs1 = int'(ins[IMM_W+RAW-1 -: RAW]);
    rs2 = int'(ins[IMM_W-1:0]) % REGS;
    m   = 64'd1 << WIDTH;
    a   = (rs1 == 0) ? 0 : longint'(mregs[rs1]);
    b   = (rs2 == 0) ? 0 : longint'(mregs[rs2]);
    ea  = WIDTH'(a);
    eb  = WIDTH'(b);
    long_div = 1'b0;
    wr = 1'b0; rep = 1'b1; e = 1'b0; v = 0;
    case (op)
      0: rep = 1'b0;
      1: begin v = (a + b) % m; wr = 1'b1; end
      2: begin v = (a + m - b) % m; wr = 1'b1; end
      3: begin v = (a * b) % m; wr = 1'b1; end
      4: begin
        if (!DIV_EN) e = 1'b1;
        else if (b == 0) begin v = m - 1; e = 1'b1; wr = 1'b1; end
        else begin v = a / b; wr = 1'b1; long_div = 1'b1; end
      end
      5: begin v = longint'(ins[IMM_W-1:0]); wr = 1'b1; ea = '0; eb = WIDTH'(v); end
      6: begin v = a & b; wr = 1'b1; end
      7: begin v = a | b; wr = 1'b1; end
      default: e = 1'b1;
    endcase
    if (rep) q.push_back('{res: WIDTH'(v), rd: RAW'(rd), err: e,
                          at: cyc + 1 + (long_div ? WIDTH : 0)});
    if (wr && rd != 0) mregs[rd] = WIDTH'(v);
  endtask

  // Driver: called at a falling edge; returns at the falling edge after completion
  task automatic issue(input logic [IW-1:0] ins);
    int n;
    logic long_div;
    logic [WIDTH-1:0] ea, eb;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin n++; @(negedge clk); end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL ready_timeout: in_ready %b, expected 1", in_ready);
    end
    model(ins, long_div, ea, eb);
    instr    = ins;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("op_a", op_a, ea);
    chk("op_b", op_b, eb);
    if (long_div) begin
      n = 0;
      while (in_ready !== 1'b1 && n < 100) begin
        in_valid = 1'b1;
        instr    = IW'($urandom);
        n++;
        @(negedge clk);
      end
      in_valid = 1'b0;
      chk("div_busy_cycles", n, WIDTH);
    end else begin
      chk("ready_after_single", in_ready, 1'b1);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_result", result, 0);
    chk("rst_result_rd", result_rd, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_op_a", op_a, 0);
    chk("rst_op_b", op_b, 0);
    chk("rst_in_ready", in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    logic long_div;
    logic [WIDTH-1:0] ea, eb;
    reset = 1'b1; in_valid = 1'b0; instr = '0;
    for (int i = 0; i < REGS; i++) mregs[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_reset_outputs();

    issue(enc(5, 1, 0, 5));
    issue(enc(5, 2, 0, 3));
    issue(enc(1, 3, 1, 2));
    chk("add_5_3", result, 8);
    chk("add_rd", result_rd, 3);
    issue(enc(2, 4, 2, 1));
    chk("sub_wrap", result, 16'hFFFE);
    issue(enc(5, 5, 0, 63));
    issue(enc(3, 6, 5, 5));
    chk("mul_63", result, 16'h0F81);
    issue(enc(6, 7, 6, 5));
    chk("and", result, 16'h0001);
    issue(enc(7, 7, 1, 2));
    chk("or", result, 16'h0007);

    issue(enc(5, 1, 0, 50));
    issue(enc(5, 2, 0, 7));
    issue(enc(4, 3, 1, 2));
    chk("div_50_7", result, DIV_EN ? 7 : 0);
    chk("div_err", err, DIV_EN ? 0 : 1);
    issue(enc(1, 4, 3, 0));
    chk("div_writeback", result, DIV_EN ? 7 : 8);
    issue(enc(4, 3, 1, 0));
    chk("div_by_zero", result, DIV_EN ? 16'hFFFF : 16'h0000);
    chk("div_by_zero_err", err, 1);
    issue(enc(5, 0, 0, 9));
    issue(enc(1, 1, 0, 0));
    chk("r0_reads_zero", result, 0);
    issue(enc(15, 2, 1, 1));
    chk("illegal_result", result, 0);
    chk("illegal_err", err, 1);
    issue(enc(1, 5, 2, 0));
    chk("illegal_no_write", result, 7);

    // Reset in the middle of a division
    issue(enc(5, 1, 0, 40));
    issue(enc(5, 2, 0, 3));
    model(enc(4, 3, 1, 2), long_div, ea, eb);
    instr = enc(4, 3, 1, 2);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    if (long_div) void'(q.pop_back());
    reset = 1'b1;
    @(posedge clk);
    for (int i = 0; i < REGS; i++) mregs[i] = '0;
    @(negedge clk);
    reset = 1'b0;
    check_reset_outputs();
    issue(enc(1, 4, 1, 2));
    chk("regs_cleared", result, 0);

    for (int i = 0; i < 300; i++) begin
      int op;
      op = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 7);
      issue(enc(op, $urandom_range(0, REGS - 1), $urandom_range(0, REGS - 1),
                $urandom_range(0, (1 << IMM_W) - 1)));
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
